// File: rtl/itcm_icb_arbiter_if.sv
// ----------------------------------------------------------------------------
// itcm_icb_arbiter_if
//   One ICB link (command + response channel).
//   master modport : drives the command fields and rsp_ready.
//   slave  modport : drives cmd_ready, rsp_valid and rsp_rdata.
//   Parameters     : AW address width, DW data width (wmask is DW/8 bits).
// ----------------------------------------------------------------------------
interface itcm_icb_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_read;
    logic [AW-1:0]     cmd_addr;
    logic [DW-1:0]     cmd_wdata;
    logic [DW/8-1:0]   cmd_wmask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_rdata;

    modport master (
        output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/itcm_icb_arbiter.sv
// ----------------------------------------------------------------------------
// itcm_icb_arbiter
//   Two-master ICB arbiter in front of a single ITCM SRAM controller.
//   m0 is the instruction-fetch master (read-only), m1 the LSU master.
//   Commands pass combinationally to the slave; an owner FIFO records who
//   issued each outstanding command so in-order responses can be routed
//   back. A flush pulse marks outstanding m0 entries as killed so their
//   responses are consumed silently.
//
//   Ports:
//     clk     : clock, all state on rising edge
//     rst     : synchronous active-high reset
//     flush   : pipeline flush pulse, kills in-flight ifetch responses
//     m0_icb  : ifetch master link (slave modport)
//     m1_icb  : LSU master link (slave modport)
//     s_icb   : SRAM controller link (master modport)
//
//   Configuration macro ITCM_ARB_RR_EN:
//     defined   -> round-robin between the masters
//     undefined -> fixed priority, m1 wins whenever unlocked
// ----------------------------------------------------------------------------
module itcm_icb_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int OUTS_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    itcm_icb_arbiter_if.slave   m0_icb,
    itcm_icb_arbiter_if.slave   m1_icb,
    itcm_icb_arbiter_if.master  s_icb
);

    localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

    owner_e                  owner_q [OUTS_DEPTH];
    owner_e                  owner_d [OUTS_DEPTH];
    logic [OUTS_DEPTH-1:0]   kill_q, kill_d;
    logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    lock_q, lock_d;
    owner_e                  lock_own_q, lock_own_d;
    logic                    blk_q;      // high for the cycle after reset release
`ifdef ITCM_ARB_RR_EN
    owner_e                  prio_q, prio_d;
`endif

    owner_e grant;
    logic   blk, full, empty, cmd_open, gnt_valid, gnt_ready, cmd_hs;
    owner_e head_own;
    logic   head_kill, rsp_open, rsp_hs;

    assign blk   = rst | blk_q;
    assign full  = (cnt_q == CW'(OUTS_DEPTH));
    assign empty = (cnt_q == '0);

    // ---------------- arbitration ----------------
    always_comb begin
        if (lock_q) begin
            grant = lock_own_q;
        end else if (m0_icb.cmd_valid && m1_icb.cmd_valid) begin
`ifdef ITCM_ARB_RR_EN
            grant = prio_q;
`else
            grant = OWN_M1;
`endif
        end else if (m0_icb.cmd_valid) begin
            grant = OWN_M0;
        end else begin
            grant = OWN_M1;
        end
    end

    // ---------------- command path ----------------
    assign cmd_open  = ~blk & ~full;
    assign gnt_valid = (grant == OWN_M1) ? m1_icb.cmd_valid : m0_icb.cmd_valid;
    assign gnt_ready = s_icb.cmd_ready & cmd_open;

    assign s_icb.cmd_valid = gnt_valid & cmd_open;
    assign s_icb.cmd_read  = (grant == OWN_M1) ? m1_icb.cmd_read  : 1'b1;
    assign s_icb.cmd_addr  = (grant == OWN_M1) ? m1_icb.cmd_addr  : m0_icb.cmd_addr;
    assign s_icb.cmd_wdata = (grant == OWN_M1) ? m1_icb.cmd_wdata : '0;
    assign s_icb.cmd_wmask = (grant == OWN_M1) ? m1_icb.cmd_wmask : '0;

    assign m0_icb.cmd_ready = (grant == OWN_M0) & gnt_ready;
    assign m1_icb.cmd_ready = (grant == OWN_M1) & gnt_ready;

    assign cmd_hs = s_icb.cmd_valid & s_icb.cmd_ready;

    // ---------------- response path ----------------
    assign head_own  = owner_q[rptr_q];
    assign head_kill = kill_q[rptr_q];
    assign rsp_open  = ~blk & ~empty;

    // Killed heads are drained without involving either master.
    assign s_icb.rsp_ready = rsp_open &
        (head_kill | ((head_own == OWN_M1) ? m1_icb.rsp_ready : m0_icb.rsp_ready));
    assign m0_icb.rsp_valid = rsp_open & ~head_kill & (head_own == OWN_M0) & s_icb.rsp_valid;
    assign m1_icb.rsp_valid = rsp_open & ~head_kill & (head_own == OWN_M1) & s_icb.rsp_valid;
    assign m0_icb.rsp_rdata = s_icb.rsp_rdata;
    assign m1_icb.rsp_rdata = s_icb.rsp_rdata;

    assign rsp_hs = s_icb.rsp_valid & s_icb.rsp_ready;

    // ---------------- next state ----------------
    always_comb begin
        owner_d    = owner_q;
        kill_d     = kill_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        // Flush marks every m0 slot; stale slots are rewritten on push, so
        // tagging them too is harmless and avoids a range compare.
        for (int unsigned i = 0; i < OUTS_DEPTH; i++) begin
            if (flush && (owner_q[i] == OWN_M0)) begin
                kill_d[i] = 1'b1;
            end
        end
        if (cmd_hs) begin
            owner_d[wptr_q] = grant;
            kill_d[wptr_q]  = flush & (grant == OWN_M0);
            wptr_d          = wptr_q + PW'(1);
        end
        if (rsp_hs) begin
            rptr_d = rptr_q + PW'(1);
        end
        cnt_d = cnt_q + CW'(cmd_hs) - CW'(rsp_hs);

        // Lock is re-evaluated every cycle: held while the granted command
        // waits, released by its handshake (or if the master withdraws).
        lock_d     = gnt_valid & ~gnt_ready;
        lock_own_d = grant;
    end

`ifdef ITCM_ARB_RR_EN
    // Priority moves to the master that was not just served.
    always_comb begin
        prio_d = prio_q;
        if (cmd_hs) begin
            prio_d = (grant == OWN_M0) ? OWN_M1 : OWN_M0;
        end
    end
`endif

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < OUTS_DEPTH; i++) begin
                owner_q[i] <= OWN_M1;
            end
            kill_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            lock_q     <= 1'b0;
            lock_own_q <= OWN_M1;
            blk_q      <= 1'b1;
`ifdef ITCM_ARB_RR_EN
            prio_q     <= OWN_M1;
`endif
        end else begin
            owner_q    <= owner_d;
            kill_q     <= kill_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            lock_q     <= lock_d;
            lock_own_q <= lock_own_d;
            blk_q      <= 1'b0;
`ifdef ITCM_ARB_RR_EN
            prio_q     <= prio_d;
`endif
        end
    end

endmodule
